pi_host_master: RTL and testbench

//  Initiator end of the 4-bit-address / 8-bit-data processor interface (PI) used by the register blocks.

---
 rtl/pi_host_master_if.sv | 32 +++
 rtl/pi_host_master.sv | 151 +++++++++++++++
 tb/tb_pi_host_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_host_master_if.sv
// Host-side byte stream, response handshake and PI register bus seen by pi_host_master.
// The master modport is the initiator; the slave modport is the host/PI-block side.
interface pi_host_master_if #(
    parameter int NUM_BLK = 8
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [NUM_BLK-1:0] pi_blk_sel;
    logic [3:0]         pi_addr;
    logic               pi_wr_en;
    logic               pi_rd_en;
    logic [7:0]         pi_wr_data;
    logic [7:0]         pi_rd_data;
    logic               busy;
    logic               err_timeout;
    logic               err_overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, pi_rd_data,
        output tx_data, tx_valid, pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en,
               pi_wr_data, busy, err_timeout, err_overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, pi_rd_data,
        input  tx_data, tx_valid, pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en,
               pi_wr_data, busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/pi_host_master.sv
// PI initiator: decodes host command/data bytes into single-cycle PI write/read strobes
// and returns read bytes over a valid/ready handshake. Every output is a register.
module pi_host_master #(
    parameter int NUM_BLK     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    pi_host_master_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WR,
        S_RD,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         blk_q, blk_d;
    logic [3:0]         addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [NUM_BLK-1:0] sel_q, sel_d;
    logic [3:0]         pi_addr_q, pi_addr_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               err_to_q, err_to_d;
    logic               err_ov_q, err_ov_d;

    logic               take_cmd;
    logic               strobe;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        err_to_d  = 1'b0;
        err_ov_d  = 1'b0;
        take_cmd  = 1'b0;

        case (state_q)
            S_IDLE: take_cmd = bus.rx_valid;
            S_WDATA: begin
                // A byte arriving on the timeout cycle still wins over the timeout.
                if (bus.rx_valid) begin
                    wr_data_d = bus.rx_data;
                    state_d   = S_WR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR: begin
                state_d  = S_IDLE;
                take_cmd = bus.rx_valid;
            end
            S_RD: begin
                tx_data_d = rd_en_q ? bus.pi_rd_data : 8'h00;
                state_d   = S_RESP;
                err_ov_d  = bus.rx_valid;
            end
            S_RESP: begin
                if (bus.tx_ready) state_d = S_IDLE;
                err_ov_d = bus.rx_valid;
            end
            default: state_d = S_IDLE;
        endcase

        if (take_cmd) begin
            blk_d  = bus.rx_data[6:4];
            addr_d = bus.rx_data[3:0];
            if (bus.rx_data[7]) begin
                state_d = S_RD;
            end else begin
                state_d = S_WDATA;
                cnt_d   = '0;
            end
        end

        // Outputs are derived from the next state so they line up with it after the edge.
        strobe = (state_d == S_WR) || (state_d == S_RD);
        for (int i = 0; i < NUM_BLK; i++) begin
            sel_d[i] = strobe && (int'(blk_d) == i);
        end
        wr_en_d    = (state_d == S_WR) && (|sel_d);
        rd_en_d    = (state_d == S_RD) && (|sel_d);
        pi_addr_d  = strobe ? addr_d : pi_addr_q;
        tx_valid_d = (state_d == S_RESP);
        busy_d     = (state_d != S_IDLE);
    end

    // NOTE: reset is synchronous and clears every register, so outputs are 0 right after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            sel_q      <= '0;
            pi_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_ov_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            sel_q      <= sel_d;
            pi_addr_q  <= pi_addr_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            err_to_q   <= err_to_d;
            err_ov_q   <= err_ov_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.pi_blk_sel  = sel_q;
    assign bus.pi_addr     = pi_addr_q;
    assign bus.pi_wr_en    = wr_en_q;
    assign bus.pi_rd_en    = rd_en_q;
    assign bus.pi_wr_data  = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_to_q;
    assign bus.err_overrun = err_ov_q;
endmodule

// File: tb/tb_pi_host_master.sv
// Directed bench for pi_host_master: an 8-block instance and a 4-block instance,
// both with a 16-cycle write-data timeout.
module tb_pi_host_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pi_host_master_if #(.NUM_BLK(8)) bus_a ();
    pi_host_master_if #(.NUM_BLK(4)) bus_b ();

    logic [7:0] rd_val_a;
    assign bus_a.pi_rd_data = bus_a.pi_rd_en ? rd_val_a : 8'h00;
    // Block B's slaves drive a nonzero value at all times, so a 00 response must come from the master.
    assign bus_b.pi_rd_data = 8'hEE;

    pi_host_master #(.NUM_BLK(8), .TIMEOUT_CYC(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pi_host_master #(.NUM_BLK(4), .TIMEOUT_CYC(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt_a = 0, rd_cnt_a = 0, both_a = 0;
    int wr_cnt_b = 0, rd_cnt_b = 0, both_b = 0;

    always @(negedge clk) begin
        if (bus_a.pi_wr_en === 1'b1) wr_cnt_a++;
        if (bus_a.pi_rd_en === 1'b1) rd_cnt_a++;
        if (bus_a.pi_wr_en === 1'b1 && bus_a.pi_rd_en === 1'b1) both_a++;
        if (bus_b.pi_wr_en === 1'b1) wr_cnt_b++;
        if (bus_b.pi_rd_en === 1'b1) rd_cnt_b++;
        if (bus_b.pi_wr_en === 1'b1 && bus_b.pi_rd_en === 1'b1) both_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        bus_a.rx_data  = b;
        bus_a.rx_valid = 1'b1;
        step();
        bus_a.rx_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        bus_b.rx_data  = b;
        bus_b.rx_valid = 1'b1;
        step();
        bus_b.rx_valid = 1'b0;
    endtask

    initial begin
        int vcnt, bad, wr_snap, rd_snap;
        bus_a.rx_data = 8'h00; bus_a.rx_valid = 1'b0; bus_a.tx_ready = 1'b0;
        bus_b.rx_data = 8'h00; bus_b.rx_valid = 1'b0; bus_b.tx_ready = 1'b0;
        rd_val_a = 8'h00;

        rst = 1'b1;
        step(); step();
        check("rst_busy",     bus_a.busy,        0);
        check("rst_tx_valid", bus_a.tx_valid,    0);
        check("rst_tx_data",  bus_a.tx_data,     0);
        check("rst_sel",      bus_a.pi_blk_sel,  0);
        check("rst_addr",     bus_a.pi_addr,     0);
        check("rst_wr_en",    bus_a.pi_wr_en,    0);
        check("rst_rd_en",    bus_a.pi_rd_en,    0);
        check("rst_wr_data",  bus_a.pi_wr_data,  0);
        check("rst_err_to",   bus_a.err_timeout, 0);
        check("rst_err_ov",   bus_a.err_overrun, 0);
        rst = 1'b0;
        step();

        // Plain write: 25 then A5.
        send_a(8'h25);
        check("wr_wdata_busy", bus_a.busy,     1);
        check("wr_early_en",   bus_a.pi_wr_en, 0);
        send_a(8'hA5);
        check("wr_en",      bus_a.pi_wr_en,   1);
        check("wr_sel",     bus_a.pi_blk_sel, 8'b0000_0100);
        check("wr_addr",    bus_a.pi_addr,    5);
        check("wr_data",    bus_a.pi_wr_data, 8'hA5);
        step();
        check("wr_end_en",   bus_a.pi_wr_en,   0);
        check("wr_end_sel",  bus_a.pi_blk_sel, 0);
        check("wr_end_busy", bus_a.busy,       0);
        check("wr_hold_addr", bus_a.pi_addr,   5);
        check("wr_hold_data", bus_a.pi_wr_data, 8'hA5);
        check("wr_count",    wr_cnt_a,         1);

        // Write to block 3, then a read command arriving during the WR cycle.
        send_a(8'h3A);
        send_a(8'h5C);
        check("wr2_en",   bus_a.pi_wr_en,   1);
        check("wr2_sel",  bus_a.pi_blk_sel, 8'b0000_1000);
        check("wr2_addr", bus_a.pi_addr,    4'hA);
        rd_val_a = 8'h3C;
        send_a(8'h93);
        check("rd_en",    bus_a.pi_rd_en,   1);
        check("rd_wr_en", bus_a.pi_wr_en,   0);
        check("rd_sel",   bus_a.pi_blk_sel, 8'b0000_0010);
        check("rd_addr",  bus_a.pi_addr,    3);
        step();
        check("rd_end_en",   bus_a.pi_rd_en, 0);
        check("rd_tx_valid", bus_a.tx_valid, 1);
        check("rd_tx_data",  bus_a.tx_data,  8'h3C);
        vcnt = 0;
        bad  = 0;
        for (int i = 0; i < 20 && bus_a.tx_valid === 1'b1; i++) begin
            vcnt++;
            if (bus_a.tx_data !== 8'h3C) bad++;
            bus_a.tx_ready = (vcnt >= 6);
            step();
        end
        bus_a.tx_ready = 1'b0;
        check("resp_valid_cycles", vcnt, 6);
        check("resp_data_stable",  bad,  0);
        check("resp_end_busy",     bus_a.busy, 0);
        check("rd_count",          rd_cnt_a,   1);

        // Timeout: 10 then silence.
        wr_snap = wr_cnt_a;
        send_a(8'h10);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (bus_a.err_timeout !== 1'b0) bad++;
        end
        step();
        check("to_early",  bad,               0);
        check("to_pulse",  bus_a.err_timeout, 1);
        check("to_busy",   bus_a.busy,        0);
        check("to_no_wr",  wr_cnt_a,          wr_snap);
        step();
        check("to_pulse_end", bus_a.err_timeout, 0);
        rd_val_a = 8'h5A;
        send_a(8'h80);
        check("to_next_rd",  bus_a.pi_rd_en,   1);
        check("to_next_sel", bus_a.pi_blk_sel, 8'b0000_0001);
        bus_a.tx_ready = 1'b1;
        step();
        check("to_next_tx", bus_a.tx_data,  8'h5A);
        check("to_next_tv", bus_a.tx_valid, 1);
        step();
        check("to_next_tv_end", bus_a.tx_valid, 0);
        bus_a.tx_ready = 1'b0;

        // Data byte arriving on the very cycle the timeout would fire.
        send_a(8'h1E);
        repeat (15) step();
        send_a(8'hC3);
        check("tolast_wr_en", bus_a.pi_wr_en,    1);
        check("tolast_no_to", bus_a.err_timeout, 0);
        check("tolast_data",  bus_a.pi_wr_data,  8'hC3);
        check("tolast_sel",   bus_a.pi_blk_sel,  8'b0000_0010);
        check("tolast_addr",  bus_a.pi_addr,     4'hE);
        step();
        check("tolast_no_to2", bus_a.err_timeout, 0);

        // Overrun: 80 then 11 during the response wait.
        wr_snap  = wr_cnt_a;
        rd_snap  = rd_cnt_a;
        rd_val_a = 8'h77;
        send_a(8'h80);
        step();
        send_a(8'h11);
        check("ov_pulse", bus_a.err_overrun, 1);
        check("ov_tv",    bus_a.tx_valid,    1);
        step();
        check("ov_pulse_end", bus_a.err_overrun, 0);
        check("ov_tx_data",   bus_a.tx_data,     8'h77);
        bus_a.tx_ready = 1'b1;
        step();
        check("ov_tv_end", bus_a.tx_valid, 0);
        repeat (3) step();
        check("ov_idle_busy", bus_a.busy,     0);
        check("ov_one_resp",  bus_a.tx_valid, 0);
        check("ov_no_wr",     wr_cnt_a,       wr_snap);
        check("ov_one_rd",    rd_cnt_a,       rd_snap + 1);
        bus_a.tx_ready = 1'b0;

        // Reset while a response is pending, then a normal write.
        rd_val_a = 8'h3C;
        send_a(8'h93);
        step();
        check("rr_tv_before", bus_a.tx_valid, 1);
        rst = 1'b1;
        step();
        check("rr_tv",   bus_a.tx_valid, 0);
        check("rr_busy", bus_a.busy,     0);
        rst = 1'b0;
        send_a(8'h42);
        send_a(8'h77);
        check("rr_wr_en",   bus_a.pi_wr_en,   1);
        check("rr_wr_sel",  bus_a.pi_blk_sel, 8'b0001_0000);
        check("rr_wr_addr", bus_a.pi_addr,    2);
        check("rr_wr_data", bus_a.pi_wr_data, 8'h77);
        step();

        // Out-of-range blocks on the 4-block instance.
        bus_b.tx_ready = 1'b1;
        send_b(8'hF0);
        check("bb_rd_en", bus_b.pi_rd_en,   0);
        check("bb_sel",   bus_b.pi_blk_sel, 0);
        check("bb_busy",  bus_b.busy,       1);
        step();
        check("bb_tv",      bus_b.tx_valid, 1);
        check("bb_tx_data", bus_b.tx_data,  8'h00);
        step();
        check("bb_tv_end",  bus_b.tx_valid, 0);
        send_b(8'h70);
        send_b(8'h55);
        check("bb_wr_en",  bus_b.pi_wr_en,   0);
        check("bb_wr_sel", bus_b.pi_blk_sel, 0);
        check("bb_wr_busy", bus_b.busy,      1);
        step();
        check("bb_wr_idle", bus_b.busy, 0);
        send_b(8'h35);
        send_b(8'h11);
        check("bb_ok_wr_en", bus_b.pi_wr_en,   1);
        check("bb_ok_sel",   bus_b.pi_blk_sel, 4'b1000);
        check("bb_ok_addr",  bus_b.pi_addr,    5);
        check("bb_ok_data",  bus_b.pi_wr_data, 8'h11);
        step();
        check("bb_wr_count", wr_cnt_b, 1);
        check("bb_rd_count", rd_cnt_b, 0);
        check("excl_a",      both_a,   0);
        check("excl_b",      both_b,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
